// File: rtl/shift_operand_stage_if.sv
// Bundle between the issue pipe, the register-file read port and the barrel shifter.
// The stage uses the slave view; the surrounding pipeline (or a bench) uses the master view.
interface shift_operand_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc_in;
   logic [3:0]  rf_addr;
   logic [31:0] rf_data;
   logic        out_valid;
   logic        out_ready;
   logic        vimm;
   logic        bimm;
   logic        shift;
   logic [1:0]  shift_type;
   logic [7:0]  valimm;
   logic [31:0] valreg;
   logic [31:0] byimm;
   logic [7:0]  byreg;
   logic [31:0] instr_out;

   modport master (
      output in_valid, instr, pc_in, rf_data, out_ready,
      input  in_ready, rf_addr, out_valid, vimm, bimm, shift, shift_type,
             valimm, valreg, byimm, byreg, instr_out
   );

   modport slave (
      input  in_valid, instr, pc_in, rf_data, out_ready,
      output in_ready, rf_addr, out_valid, vimm, bimm, shift, shift_type,
             valimm, valreg, byimm, byreg, instr_out
   );
endinterface

// File: rtl/shift_operand_stage.sv
// Operand-2 issue stage: decodes the shifter operand, reads Rs/Rm over one read port
// and holds a stable bundle for the barrel shifter until it is consumed.
module shift_operand_stage #(
   parameter logic [31:0] PC_OFS_IMM = 32'd8,
   parameter logic [31:0] PC_OFS_REG = 32'd12
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  flush,
   shift_operand_stage_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ_RS, READ_RM, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;
   logic        accept;
   logic [31:0] rd_val;

   logic        d_vimm, d_bimm, d_shift;
   logic [1:0]  d_type;
   logic [31:0] d_byimm;
   logic [4:0]  amt;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == HOLD);
   assign accept        = bus.in_valid && (state == IDLE) && !flush;

   // NOTE: every variable is given a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) begin
                     if (bus.instr[25])     state_nxt = HOLD;
                     else if (bus.instr[4]) state_nxt = READ_RS;
                     else                   state_nxt = READ_RM;
                  end
         READ_RS: state_nxt = READ_RM;
         READ_RM: state_nxt = HOLD;
         HOLD:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_comb begin
      bus.rf_addr = 4'd0;
      case (state)
         READ_RS: bus.rf_addr = bus.instr_out[11:8];
         READ_RM: bus.rf_addr = bus.instr_out[3:0];
         default: bus.rf_addr = 4'd0;
      endcase
   end

   // The PC is architecturally ahead of the instruction; register-shift forms see one more word.
   always_comb begin
      rd_val = bus.rf_data;
      if (bus.rf_addr == 4'd15)
         rd_val = pc_q + (bus.instr_out[4] ? PC_OFS_REG : PC_OFS_IMM);
   end

   // Operand-2 decode of the incoming word, captured on accept.
   always_comb begin
      amt     = bus.instr[11:7];
      d_vimm  = 1'b0;
      d_bimm  = 1'b1;
      d_shift = 1'b1;
      d_type  = bus.instr[6:5];
      d_byimm = 32'd0;
      if (bus.instr[25]) begin
         d_vimm  = 1'b1;
         d_type  = 2'd3;
         d_byimm = {27'd0, bus.instr[11:8], 1'b0};
      end else if (bus.instr[4]) begin
         d_bimm  = 1'b0;
      end else if (amt == 5'd0) begin
         case (bus.instr[6:5])
            2'd0:    d_shift = 1'b0;
            2'd3:    d_byimm = 32'd0;
            default: d_byimm = 32'd32;
         endcase
      end else begin
         d_byimm = {27'd0, amt};
      end
   end

   // NOTE: state and outputs are updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc_q           <= 32'd0;
         bus.vimm       <= 1'b0;
         bus.bimm       <= 1'b0;
         bus.shift      <= 1'b0;
         bus.shift_type <= 2'd0;
         bus.valimm     <= 8'd0;
         bus.valreg     <= 32'd0;
         bus.byimm      <= 32'd0;
         bus.byreg      <= 8'd0;
         bus.instr_out  <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pc_q           <= bus.pc_in;
            bus.instr_out  <= bus.instr;
            bus.vimm       <= d_vimm;
            bus.bimm       <= d_bimm;
            bus.shift      <= d_shift;
            bus.shift_type <= d_type;
            bus.valimm     <= bus.instr[7:0];
            bus.byimm      <= d_byimm;
         end
         if (state == READ_RS && !flush) bus.byreg  <= rd_val[7:0];
         if (state == READ_RM && !flush) bus.valreg <= rd_val;
      end
   end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Bench for shift_operand_stage: vector table with a scoreboard queue, plus
// hand-written backpressure, flush and mid-operation reset sequences.
module tb_shift_operand_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      int          lat;
      logic [3:0]  a1;
      logic [3:0]  a2;
      logic        vimm;
      logic        bimm;
      logic        shift;
      logic [1:0]  stype;
      logic [31:0] byimm;
      logic [31:0] valreg;
      logic [7:0]  byreg;
      bit          chk_valreg;
      bit          chk_byreg;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic [31:0] regs [16];
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs [11];
   vec_t exp_q [$];

   shift_operand_stage_if bus ();

   shift_operand_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.rf_data = regs[bus.rf_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input int lat,
                               input logic [3:0] a1, input logic [3:0] a2,
                               input logic vimm, input logic bimm, input logic shift,
                               input logic [1:0] stype, input logic [31:0] byimm,
                               input logic [31:0] valreg, input logic [7:0] byreg,
                               input bit cv, input bit cb);
      vec_t v;
      v.instr = instr;  v.pc = pc;  v.lat = lat;  v.a1 = a1;  v.a2 = a2;
      v.vimm = vimm;  v.bimm = bimm;  v.shift = shift;  v.stype = stype;
      v.byimm = byimm;  v.valreg = valreg;  v.byreg = byreg;
      v.chk_valreg = cv;  v.chk_byreg = cb;
      return v;
   endfunction

   task automatic compare_bundle(input vec_t e);
      check("vimm",      {31'd0, bus.vimm},       {31'd0, e.vimm});
      check("bimm",      {31'd0, bus.bimm},       {31'd0, e.bimm});
      check("shift",     {31'd0, bus.shift},      {31'd0, e.shift});
      check("type",      {30'd0, bus.shift_type}, {30'd0, e.stype});
      check("byimm",     bus.byimm,               e.byimm);
      check("valimm",    {24'd0, bus.valimm},     {24'd0, e.instr[7:0]});
      check("instr_out", bus.instr_out,           e.instr);
      if (e.chk_valreg) check("valreg", bus.valreg, e.valreg);
      if (e.chk_byreg)  check("byreg",  {24'd0, bus.byreg}, {24'd0, e.byreg});
   endtask

   // Issue one instruction, follow it to HOLD, optionally stall, then let it drain.
   task automatic run_vec(input vec_t v, input int hold);
      int   cyc;
      bit   done;
      vec_t e;
      logic [31:0] vr_snap, bi_snap;
      @(negedge clk);
      check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.instr     = v.instr;
      bus.pc_in     = v.pc;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      exp_q.push_back(v);
      cyc  = 0;
      done = 0;
      while (!done && cyc < 8) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         cyc++;
         if (cyc == 1) check("rf_addr_c1", {28'd0, bus.rf_addr}, {28'd0, (v.lat > 1) ? v.a1 : 4'd0});
         if (cyc == 2 && v.lat == 3) check("rf_addr_c2", {28'd0, bus.rf_addr}, {28'd0, v.a2});
         if (bus.out_valid) done = 1;
      end
      check("latency", cyc, v.lat);
      if (done && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare_bundle(e);
      end
      vr_snap = bus.valreg;
      bi_snap = bus.byimm;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid",  {31'd0, bus.out_valid}, 32'd1);
         check("hold_ready",  {31'd0, bus.in_ready},  32'd0);
         check("hold_valreg", bus.valreg, vr_snap);
         check("hold_byimm",  bus.byimm,  bi_snap);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
      check("drain_ready", {31'd0, bus.in_ready},  32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'hA5A5_0000 | i;
      regs[1] = 32'h8000_0000;
      regs[2] = 32'h0000_0001;
      regs[3] = 32'h0000_0105;

      //            instr          pc        lat a1     a2     vi bi sh ty byimm   valreg        byreg  cv cb
      vecs[0]  = mk(32'hE3A004FF, 32'h100, 1, 4'd0,  4'd0,  1, 1, 1, 3, 32'd8,  32'd0,        8'h00, 0, 0);
      vecs[1]  = mk(32'hE1A00221, 32'h100, 2, 4'd1,  4'd0,  0, 1, 1, 1, 32'd4,  32'h80000000, 8'h00, 1, 0);
      vecs[2]  = mk(32'hE1A00021, 32'h100, 2, 4'd1,  4'd0,  0, 1, 1, 1, 32'd32, 32'h80000000, 8'h00, 1, 0);
      vecs[3]  = mk(32'hE1A00061, 32'h100, 2, 4'd1,  4'd0,  0, 1, 1, 3, 32'd0,  32'h80000000, 8'h00, 1, 0);
      vecs[4]  = mk(32'hE1A00001, 32'h100, 2, 4'd1,  4'd0,  0, 1, 0, 0, 32'd0,  32'h80000000, 8'h00, 1, 0);
      vecs[5]  = mk(32'hE1A00FC1, 32'h100, 2, 4'd1,  4'd0,  0, 1, 1, 2, 32'd31, 32'h80000000, 8'h00, 1, 0);
      vecs[6]  = mk(32'hE1A00312, 32'h100, 3, 4'd3,  4'd2,  0, 0, 1, 0, 32'd0,  32'h1,        8'h05, 1, 1);
      vecs[7]  = mk(32'hE1A0000F, 32'h100, 2, 4'd15, 4'd0,  0, 1, 0, 0, 32'd0,  32'h108,      8'h00, 1, 0);
      vecs[8]  = mk(32'hE1A0031F, 32'h100, 3, 4'd3,  4'd15, 0, 0, 1, 0, 32'd0,  32'h10C,      8'h05, 1, 1);
      vecs[9]  = mk(32'hE1A00F12, 32'h100, 3, 4'd15, 4'd2,  0, 0, 1, 0, 32'd0,  32'h1,        8'h0C, 1, 1);
      vecs[10] = mk(32'hE3A000AB, 32'h100, 1, 4'd0,  4'd0,  1, 1, 1, 3, 32'd0,  32'd0,        8'h00, 0, 0);

      rst_n = 1'b0;  flush = 1'b0;
      bus.in_valid = 1'b0;  bus.instr = 32'd0;  bus.pc_in = 32'd0;  bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_vimm",      {31'd0, bus.vimm},      32'd0);
      check("rst_byimm",     bus.byimm,              32'd0);
      check("rst_valreg",    bus.valreg,             32'd0);
      check("rst_instr_out", bus.instr_out,          32'd0);
      check("rst_rf_addr",   {28'd0, bus.rf_addr},   32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], (i == 1) ? 5 : 0);

      // Flush while reading Rs: nothing reaches the shifter.
      @(negedge clk);
      bus.in_valid = 1'b1;  bus.instr = 32'hE1A00312;  bus.pc_in = 32'h100;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("flush_rs_addr", {28'd0, bus.rf_addr}, 32'd3);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_rs_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_rs_quiet", {31'd0, bus.out_valid}, 32'd0);
      end

      // Flush in IDLE together with in_valid: the instruction is not taken.
      bus.in_valid = 1'b1;  bus.instr = 32'hE3A004FF;  flush = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;  flush = 1'b0;
      check("flush_idle_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_idle_ready", {31'd0, bus.in_ready},  32'd1);

      // Flush wins over out_ready in HOLD.
      bus.in_valid = 1'b1;  bus.instr = 32'hE3A004FF;  bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("flush_hold_pre", {31'd0, bus.out_valid}, 32'd1);
      flush = 1'b1;  bus.out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_hold_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_hold_ready", {31'd0, bus.in_ready},  32'd1);

      // Reset mid-operation clears everything, with flush asserted as well.
      bus.in_valid = 1'b1;  bus.instr = 32'hE1A00312;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;  flush = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;  flush = 1'b0;
      check("mrst_valid",     {31'd0, bus.out_valid}, 32'd0);
      check("mrst_ready",     {31'd0, bus.in_ready},  32'd1);
      check("mrst_vimm",      {31'd0, bus.vimm},      32'd0);
      check("mrst_byimm",     bus.byimm,              32'd0);
      check("mrst_valreg",    bus.valreg,             32'd0);
      check("mrst_byreg",     {24'd0, bus.byreg},     32'd0);
      check("mrst_valimm",    {24'd0, bus.valimm},    32'd0);
      check("mrst_instr_out", bus.instr_out,          32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
